uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
- Frame-sequencing controller for the UART receive path.
- Detects the start edge on rx_in and counts oversampling edges and bit positions.
- Gates the data sampler, issues shift strobes (deser_en) to the deserializer, and checks start, parity and stop bits.
- Asserts data_valid so the deserializer's gated p_data output is presented for exactly one cycle per good frame.

Parameters:
- WIDTH, 8, number of data bits per frame; must match the deserializer register width.
- PRESC_W, 6, width of the prescale input and the internal edge counter.

Ports:
- clk  input  1  receiver oversampling clock.
- rst  input  1  synchronous active-low reset, sampled on rising clk.
- rx_in  input  1  serial line, idle high; already synchronised upstream.
- prescale  input  PRESC_W  oversampling edges per bit; legal range 4..63; must be held stable while busy=1.
- par_en  input  1  1 = parity bit present after the data bits.
- par_typ  input  1  0 = even parity, 1 = odd parity.
- sampled_bit  input  1  majority-voted bit from the sampler; valid when edge_cnt == prescale-1.
- dat_samp_en  output  1  sampler enable.
- deser_en  output  1  one-cycle shift strobe to the deserializer, LSB first.
- data_valid  output  1  one-cycle pulse: frame accepted, p_data valid.
- par_err  output  1  parity mismatch for the current or last frame.
- stp_err  output  1  stop bit sampled low for the current or last frame.
- strt_glitch  output  1  one-cycle pulse: start bit sampled high.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE; edge_cnt=0; bit_cnt=0; parity accumulator=0.
  - All outputs 0.
  - Reset mid-frame aborts the frame. No data_valid is issued for the aborted frame.
- States: IDLE, START, DATA, PARITY, STOP, OUTPUT.
- edge_cnt:
  - Counts 0..prescale-1 in every non-IDLE, non-OUTPUT state.
  - Wraps to 0 at prescale-1.
  - "Bit end" means edge_cnt == prescale-1.
- IDLE: when rx_in==0, next state=START, edge_cnt=0, par_err=0, stp_err=0.
- START, at bit end:
  - sampled_bit==1: pulse strt_glitch for one cycle, go to IDLE.
  - Otherwise: go to DATA with bit_cnt=0.
- DATA, at bit end:
  - Pulse deser_en for one cycle.
  - acc ^= sampled_bit.
  - bit_cnt++.
  - When bit_cnt reaches WIDTH-1 at a bit end: go to PARITY if par_en, else STOP.
  - Exactly WIDTH deser_en pulses per frame.
- PARITY, at bit end:
  - Expected bit = acc ^ par_typ.
  - If sampled_bit != expected bit, set par_err=1.
  - Go to STOP.
- STOP, at bit end: if sampled_bit==0, set stp_err=1. Go to OUTPUT.
- OUTPUT (one cycle):
  - data_valid=1 iff (par_err|stp_err)==0 using the values just registered.
  - Go to IDLE.
  - rx_in is ignored during this cycle, so a back-to-back start bit is detected one cycle late. This is acceptable for prescale≥4.
- Latency: data_valid is asserted exactly 1 cycle after the stop-bit bit end.
- dat_samp_en=1 in START, DATA, PARITY and STOP; 0 in IDLE and OUTPUT.
- Error flag timing:
  - par_err and stp_err are registered levels.
  - They hold until the next IDLE→START transition clears them.
- par_en and par_typ are sampled on the IDLE→START transition. Changes mid-frame have no effect.
- Simultaneous events: a bit end with a state change uses sampled_bit of that cycle only. Register updates take effect on the same clk edge.

Optional Feature:
- Macro: UART_RX_BREAK_DETECT_EN.
- With the macro defined:
  - Adds output break_det (1 bit, reset 0).
  - In OUTPUT, if all WIDTH data bits were 0 (tracked with an internal OR accumulator) and stp_err==1, break_det pulses for one cycle.
  - data_valid is suppressed for that frame.
- Without the macro: no break_det port, no OR accumulator; behaviour is exactly as above.

Test Plan:
- prescale=8, par_en=0, frame 0x A5 sent LSB first with stop=1 -> 8 deser_en pulses each spaced 8 cycles; data_valid pulses 1 cycle after stop bit end; par_err=stp_err=0.
- prescale=16, par_en=1, par_typ=0, data 0x03, parity bit 0 -> data_valid=1. Repeat with parity bit 1 -> par_err=1, no data_valid.
- prescale=8, rx_in low for 2 cycles then high (sampled_bit=1 at edge 7) -> strt_glitch one pulse, state back to IDLE, zero deser_en pulses.
- prescale=8, data 0x5A, stop bit 0 -> stp_err=1 held until next start, no data_valid. Next good frame clears stp_err on its start edge.
- rst=0 asserted during DATA bit 4 -> next clk all outputs 0, busy=0. A following full frame 0xFF is received with exactly 8 deser_en pulses and data_valid=1.
- With UART_RX_BREAK_DETECT_EN: data 0x00 with stop=0 -> break_det one pulse, data_valid=0, stp_err=1.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame sequencer. Detects the start edge, counts
// oversampling edges and bit positions, strobes the deserializer and checks
// start, parity and stop bits.
// Ports: clk, rst (sync, active-low), rx_in (serial line), prescale (edges per
// bit), par_en/par_typ (parity config), sampled_bit (voted sample) in;
// dat_samp_en, deser_en, data_valid, par_err, stp_err, strt_glitch, busy out.
// Optional: define UART_RX_BREAK_DETECT_EN to add the break_det output.
module uart_rx_ctrl #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_in,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               par_en,
  input  logic               par_typ,
  input  logic               sampled_bit,
  output logic               dat_samp_en,
  output logic               deser_en,
  output logic               data_valid,
  output logic               par_err,
  output logic               stp_err,
  output logic               strt_glitch,
`ifdef UART_RX_BREAK_DETECT_EN
  output logic               break_det,
`endif
  output logic               busy
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, OUTPUT
  } state_t;

  state_t             state_q, state_d;
  logic [PRESC_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
  logic               acc_q, acc_d;
  logic               pe_q, pe_d;
  logic               pt_q, pt_d;
  logic               par_err_q, par_err_d;
  logic               stp_err_q, stp_err_d;
  logic               deser_en_q, deser_en_d;
  logic               glitch_q, glitch_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               samp_q, samp_d;
  logic               bit_end;
  logic               brk_d;
`ifdef UART_RX_BREAK_DETECT_EN
  logic               or_acc_q, or_acc_d;
  logic               brk_q;
`endif

  assign bit_end = (edge_cnt_q == prescale - PRESC_W'(1));

  always_comb begin
    state_d    = state_q;
    edge_cnt_d = '0;
    bit_cnt_d  = bit_cnt_q;
    acc_d      = acc_q;
    pe_d       = pe_q;
    pt_d       = pt_q;
    par_err_d  = par_err_q;
    stp_err_d  = stp_err_q;
    deser_en_d = 1'b0;
    glitch_d   = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
    or_acc_d   = or_acc_q;
`endif
    if (state_q inside {START, DATA, PARITY, STOP})
      edge_cnt_d = bit_end ? '0 : edge_cnt_q + PRESC_W'(1);
    unique case (state_q)
      IDLE: begin
        if (!rx_in) begin
          state_d   = START;
          par_err_d = 1'b0;
          stp_err_d = 1'b0;
          pe_d      = par_en;
          pt_d      = par_typ;
          acc_d     = 1'b0;
          bit_cnt_d = '0;
`ifdef UART_RX_BREAK_DETECT_EN
          or_acc_d  = 1'b0;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          if (sampled_bit) begin
            glitch_d = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          deser_en_d = 1'b1;
          acc_d      = acc_q ^ sampled_bit;
`ifdef UART_RX_BREAK_DETECT_EN
          or_acc_d   = or_acc_q | sampled_bit;
`endif
          if (bit_cnt_q == BW'(WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = pe_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          if (sampled_bit != (acc_q ^ pt_q))
            par_err_d = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!sampled_bit)
            stp_err_d = 1'b1;
          state_d = OUTPUT;
        end
      end
      OUTPUT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Frame verdict uses the error flags as they will be registered this edge.
`ifdef UART_RX_BREAK_DETECT_EN
    brk_d = (state_d == OUTPUT) && !or_acc_d && stp_err_d;
`else
    brk_d = 1'b0;
`endif
    valid_d = (state_d == OUTPUT) && !(par_err_d | stp_err_d) && !brk_d;
    busy_d  = (state_d != IDLE);
    samp_d  = state_d inside {START, DATA, PARITY, STOP};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      acc_q      <= 1'b0;
      pe_q       <= 1'b0;
      pt_q       <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
      deser_en_q <= 1'b0;
      glitch_q   <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      samp_q     <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      or_acc_q   <= 1'b0;
      brk_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      acc_q      <= acc_d;
      pe_q       <= pe_d;
      pt_q       <= pt_d;
      par_err_q  <= par_err_d;
      stp_err_q  <= stp_err_d;
      deser_en_q <= deser_en_d;
      glitch_q   <= glitch_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      samp_q     <= samp_d;
`ifdef UART_RX_BREAK_DETECT_EN
      or_acc_q   <= or_acc_d;
      brk_q      <= brk_d;
`endif
    end
  end

  assign dat_samp_en = samp_q;
  assign deser_en    = deser_en_q;
  assign data_valid  = valid_q;
  assign par_err     = par_err_q;
  assign stp_err     = stp_err_q;
  assign strt_glitch = glitch_q;
  assign busy        = busy_q;
`ifdef UART_RX_BREAK_DETECT_EN
  assign break_det   = brk_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed frames against a frame-level timing model
// of uart_rx_ctrl, compared every cycle, plus literal totals.
module tb_uart_rx_ctrl;

  localparam int W = 8;
  localparam int N = 1700;
  localparam int B_BUSY = 0;
  localparam int B_SAMP = 1;
  localparam int B_DES  = 2;
  localparam int B_VAL  = 3;
  localparam int B_PERR = 4;
  localparam int B_SERR = 5;
  localparam int B_GL   = 6;
  localparam int B_BRK  = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_typ;
  logic       sampled_bit;
  logic       dat_samp_en;
  logic       deser_en;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic       strt_glitch;
  logic       busy;
  logic       break_det;

  logic [7:0] expv   [N];
  logic       line   [N];
  logic       rst_a  [N];
  logic [5:0] pres_a [N];
  logic       pe_a   [N];
  logic       pt_a   [N];

  int checks = 0;
  int errors = 0;
  int n_des = 0;
  int n_val = 0;
  int n_gl  = 0;
  int n_brk = 0;
  int first_val = -1;
  int des_idx[$];

  always #5 clk = ~clk;

  uart_rx_ctrl #(.WIDTH(8), .PRESC_W(6)) dut (
    .clk(clk),
    .rst(rst),
    .rx_in(rx_in),
    .prescale(prescale),
    .par_en(par_en),
    .par_typ(par_typ),
    .sampled_bit(sampled_bit),
    .dat_samp_en(dat_samp_en),
    .deser_en(deser_en),
    .data_valid(data_valid),
    .par_err(par_err),
    .stp_err(stp_err),
    .strt_glitch(strt_glitch),
`ifdef UART_RX_BREAK_DETECT_EN
    .break_det(break_det),
`endif
    .busy(busy)
  );

`ifndef UART_RX_BREAK_DETECT_EN
  assign break_det = 1'b0;
`endif

  task automatic fill(input int b, input int from,
                      input int to, input logic v);
    for (int i = from; i <= to && i < N; i++)
      expv[i][b] = v;
  endtask

  task automatic set_cfg(input int s, input int p,
                         input logic pe, input logic pt);
    for (int i = s; i < N; i++) begin
      pres_a[i] = 6'(p);
      pe_a[i]   = pe;
      pt_a[i]   = pt;
    end
  endtask

  // Bit k of a frame (0 = start) occupies line cycles s+k*P .. s+k*P+P-1;
  // its bit end is the edge at s+(k+1)*P and registered results appear there.
  task automatic add_frame(input int s, input int p, input logic [7:0] d,
                           input logic pe, input logic pt, input logic pb,
                           input logic sb, output int se);
    int   np;
    logic perr;
    logic brk;
    np = pe ? 1 : 0;
    se = s + (W + 2 + np) * p;
    set_cfg(s, p, pe, pt);
    for (int j = 0; j < p; j++) begin
      line[s + j] = 1'b0;
      for (int k = 1; k <= W; k++)
        line[s + k * p + j] = d[k - 1];
      if (pe)
        line[s + (W + 1) * p + j] = pb;
      line[s + (W + 1 + np) * p + j] = sb;
    end
    fill(B_PERR, s, N - 1, 1'b0);
    fill(B_SERR, s, N - 1, 1'b0);
    fill(B_BUSY, s, se, 1'b1);
    fill(B_SAMP, s, se - 1, 1'b1);
    for (int k = 1; k <= W; k++)
      expv[s + (k + 1) * p][B_DES] = 1'b1;
    perr = pe && (pb != ((^d) ^ pt));
    if (perr)
      fill(B_PERR, s + (W + 2) * p, N - 1, 1'b1);
    if (!sb)
      fill(B_SERR, se, N - 1, 1'b1);
`ifdef UART_RX_BREAK_DETECT_EN
    brk = (d == 8'h00) && !sb;
`else
    brk = 1'b0;
`endif
    if (brk)
      expv[se][B_BRK] = 1'b1;
    if (!perr && sb && !brk)
      expv[se][B_VAL] = 1'b1;
  endtask

  task automatic add_glitch(input int s, input int p, output int nxt);
    set_cfg(s, p, 1'b0, 1'b0);
    line[s]     = 1'b0;
    line[s + 1] = 1'b0;
    fill(B_PERR, s, N - 1, 1'b0);
    fill(B_SERR, s, N - 1, 1'b0);
    fill(B_BUSY, s, s + p - 1, 1'b1);
    fill(B_SAMP, s, s + p - 1, 1'b1);
    expv[s + p][B_GL] = 1'b1;
    nxt = s + p + 2;
  endtask

  task automatic add_reset(input int r);
    rst_a[r] = 1'b0;
    for (int i = r; i < N; i++) begin
      expv[i] = '0;
      line[i] = 1'b1;
    end
  endtask

  task automatic drive(input int i);
    rst         = rst_a[i];
    rx_in       = line[i];
    sampled_bit = (i > 0) ? line[i - 1] : 1'b1;
    prescale    = pres_a[i];
    par_en      = pe_a[i];
    par_typ     = pt_a[i];
  endtask

  task automatic compare(input int i);
    logic [7:0] act;
    act = {break_det, strt_glitch, stp_err, par_err,
           data_valid, deser_en, dat_samp_en, busy};
    checks++;
    if (act !== expv[i]) begin
      errors++;
      $display("FAIL cycle %0d outputs got %b want %b", i, act, expv[i]);
    end
    if (deser_en === 1'b1) begin
      n_des++;
      des_idx.push_back(i);
    end
    if (data_valid === 1'b1) begin
      n_val++;
      if (first_val < 0) first_val = i;
    end
    if (strt_glitch === 1'b1) n_gl++;
    if (break_det === 1'b1) n_brk++;
  endtask

  task automatic lit(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  initial begin
    int s;
    int se;
    int last;
    for (int i = 0; i < N; i++) begin
      expv[i]   = '0;
      line[i]   = 1'b1;
      rst_a[i]  = 1'b1;
      pres_a[i] = 6'd8;
      pe_a[i]   = 1'b0;
      pt_a[i]   = 1'b0;
    end
    for (int i = 0; i < 4; i++) rst_a[i] = 1'b0;

    s = 6;
    add_frame(s, 8, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, se);
    s = se + 2;
    add_frame(s, 16, 8'h03, 1'b1, 1'b0, 1'b0, 1'b1, se);
    for (int i = s + 48; i <= se; i++) begin
      pe_a[i] = 1'b0;
      pt_a[i] = 1'b1;
    end
    s = se + 2;
    add_frame(s, 16, 8'h03, 1'b1, 1'b0, 1'b1, 1'b1, se);
    s = se + 2;
    add_glitch(s, 8, s);
    add_frame(s, 8, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, se);
    s = se + 2;
    add_frame(s, 4, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, se);
    s = se + 2;
    add_frame(s, 8, 8'h96, 1'b0, 1'b0, 1'b0, 1'b1, se);
    add_reset(s + 43);
    s = s + 46;
    add_frame(s, 8, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, se);
    s = se + 2;
    add_frame(s, 63, 8'h81, 1'b1, 1'b1, 1'b1, 1'b1, se);
    s = se + 2;
    add_frame(s, 8, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, se);
    s = se + 2;
    add_frame(s, 8, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, se);
    s = se + 2;
    add_frame(s, 6, 8'hFE, 1'b1, 1'b1, 1'b1, 1'b0, se);
    last = se + 12;

    rst = 1'b0;
    rx_in = 1'b1;
    sampled_bit = 1'b1;
    prescale = 6'd8;
    par_en = 1'b0;
    par_typ = 1'b0;

    for (int i = 0; i < last; i++) begin
      @(negedge clk);
      if (i > 0) compare(i - 1);
      drive(i);
    end
    @(negedge clk);
    compare(last - 1);

    lit("deser_total", n_des, 84);
    lit("valid_total", n_val, 6);
    lit("glitch_total", n_gl, 1);
    lit("first_valid", first_val, 86);
    lit("first_deser", (des_idx.size() > 0) ? des_idx[0] : -1, 22);
    lit("deser_gap", (des_idx.size() > 1) ? des_idx[1] - des_idx[0] : -1, 8);
    lit("eighth_deser", (des_idx.size() > 7) ? des_idx[7] : -1, 78);
`ifdef UART_RX_BREAK_DETECT_EN
    lit("break_total", n_brk, 1);
`else
    lit("break_total", n_brk, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
